// File: rtl/parity_frame_ctrl_if.sv
// Handshake bundle between the data source, the parity frame controller and the result consumer.
// The master side feeds beats and the parity bit and consumes the result; the slave side is the controller.
interface parity_frame_ctrl_if #(
    parameter int DATA_W = 4
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              par_valid;
    logic              par_bit;
    logic              par_ready;
    logic              out_valid;
    logic              out_err;
    logic              out_parity;
    logic              out_ready;

    modport master (
        output in_valid, in_data, par_valid, par_bit, out_ready,
        input  in_ready, par_ready, out_valid, out_err, out_parity
    );

    modport slave (
        input  in_valid, in_data, par_valid, par_bit, out_ready,
        output in_ready, par_ready, out_valid, out_err, out_parity
    );
endinterface

// File: rtl/parity_frame_ctrl.sv
// Frame sequencer for the nibble parity datapath: collects FRAME_LEN beats, folds their parity,
// checks it against the sender's parity bit and reports pass/fail with frame and error counters.
module parity_frame_ctrl #(
    parameter int DATA_W    = 4,
    parameter int FRAME_LEN = 4,
    parameter int EVEN      = 1,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic             abort,
    input  logic             clr_cnt,
    parity_frame_ctrl_if.slave bus,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);
    localparam int          BEAT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);
    localparam logic        EVEN_BIT  = (EVEN != 0);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        CHECK,
        RESULT
    } state_t;

    state_t            state_q, state_d;
    logic              acc_q, acc_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              out_valid_q, out_valid_d;
    logic              out_err_q, out_err_d;
    logic              out_parity_q, out_parity_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

    logic abortHit;
    logic parTake;
    logic mismatch;

    assign abortHit = abort && (state_q != IDLE);
    assign parTake  = (state_q == CHECK) && bus.par_valid;
    assign mismatch = acc_q ^ bus.par_bit ^ ~EVEN_BIT;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            acc_q        <= 1'b0;
            beat_q       <= '0;
            out_valid_q  <= 1'b0;
            out_err_q    <= 1'b0;
            out_parity_q <= 1'b0;
            frame_cnt_q  <= '0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            beat_q       <= beat_d;
            out_valid_q  <= out_valid_d;
            out_err_q    <= out_err_d;
            out_parity_q <= out_parity_d;
            frame_cnt_q  <= frame_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    // Abort pre-empts every transition, including a par handshake in the same cycle.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        beat_d       = beat_q;
        out_valid_d  = out_valid_q;
        out_err_d    = out_err_q;
        out_parity_d = out_parity_q;
        frame_cnt_d  = frame_cnt_q;
        err_cnt_d    = err_cnt_q;

        if (abortHit) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            acc_d       = 1'b0;
            beat_d      = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        state_d = COLLECT;
                        acc_d   = 1'b0;
                        beat_d  = '0;
                    end
                end
                COLLECT: begin
                    if (bus.in_valid) begin
                        acc_d = acc_q ^ (^bus.in_data);
                        if (beat_q == LAST_BEAT) begin
                            state_d = CHECK;
                        end else begin
                            beat_d = beat_q + 1'b1;
                        end
                    end
                end
                CHECK: begin
                    if (bus.par_valid) begin
                        out_parity_d = acc_q;
                        out_err_d    = mismatch;
                        out_valid_d  = 1'b1;
                        state_d      = RESULT;
                    end
                end
                RESULT: begin
                    if (bus.out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // A clear beats any increment landing on the same edge.
        if (clr_cnt) begin
            frame_cnt_d = '0;
            err_cnt_d   = '0;
        end else if (parTake && !abortHit) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
            if (mismatch && (err_cnt_q != '1)) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end
    end

    assign bus.in_ready   = (state_q == COLLECT);
    assign bus.par_ready  = (state_q == CHECK);
    assign bus.out_valid  = out_valid_q;
    assign bus.out_err    = out_err_q;
    assign bus.out_parity = out_parity_q;
    assign busy           = (state_q != IDLE);
    assign frame_cnt      = frame_cnt_q;
    assign err_cnt        = err_cnt_q;
endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Directed-plus-random bench for parity_frame_ctrl; expected results come from a bit-counting
// model of frame parity and simple wrap/saturate counter arithmetic.
module tb_parity_frame_ctrl;
    localparam int DATA_W    = 4;
    localparam int FRAME_LEN = 4;
    localparam int CNT_W     = 8;

    logic             clk = 1'b0;
    logic             n_rst;
    logic             start;
    logic             abort;
    logic             clr_cnt;
    logic             busy;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] err_cnt;

    parity_frame_ctrl_if #(.DATA_W(DATA_W)) bus ();

    parity_frame_ctrl #(
        .DATA_W(DATA_W),
        .FRAME_LEN(FRAME_LEN),
        .EVEN(1),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .start(start),
        .abort(abort),
        .clr_cnt(clr_cnt),
        .bus(bus),
        .busy(busy),
        .frame_cnt(frame_cnt),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int frameCnt = 0;
    int errCnt = 0;
    logic [DATA_W-1:0] beats [FRAME_LEN];

    // Even convention: the frame plus its parity bit must hold an even number of ones.
    function automatic bit refParity();
        int ones = 0;
        for (int i = 0; i < FRAME_LEN; i++) ones += $countones(beats[i]);
        return bit'(ones % 2);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setBeats(input logic [4*DATA_W-1:0] packed_beats);
        for (int i = 0; i < FRAME_LEN; i++) beats[i] = packed_beats[(FRAME_LEN-1-i)*DATA_W +: DATA_W];
    endtask

    task automatic randomBeats();
        for (int i = 0; i < FRAME_LEN; i++) beats[i] = DATA_W'($urandom);
    endtask

    // One complete frame with optional stalls on every handshake.
    task automatic applyStimulus(input bit stall, input int parWait, input int outWait,
                                 input bit parVal, input bit clrAtPar, input bit startAtDone,
                                 input bit checkTiming);
        int cycles = 0;
        int idx = 0;
        int guard = 0;
        bit took;
        bit expPar;
        bit expErr;
        @(negedge clk);
        start = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cycles = 1;
        while (idx < FRAME_LEN && guard < 200) begin
            bus.in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.in_data  = bus.in_valid ? beats[idx] : DATA_W'($urandom);
            #1 took = bus.in_valid && bus.in_ready;
            @(negedge clk);
            cycles++;
            guard++;
            if (took) idx++;
        end
        checkOutput("beatBudget", idx, FRAME_LEN);
        bus.in_valid = stall;
        bus.in_data  = '1;
        #1 checkOutput("inReadyInCheck", {31'd0, bus.in_ready}, 0);
        repeat (parWait) begin
            @(negedge clk);
            cycles++;
            checkOutput("outValidDuringParStall", {31'd0, bus.out_valid}, 0);
        end
        bus.par_valid = 1'b1;
        bus.par_bit   = parVal;
        clr_cnt       = clrAtPar;
        #1 checkOutput("parReady", {31'd0, bus.par_ready}, 1);
        @(negedge clk);
        cycles++;
        bus.par_valid = 1'b0;
        bus.in_valid  = 1'b0;
        clr_cnt       = 1'b0;

        expPar = refParity();
        expErr = expPar ^ parVal;
        if (clrAtPar) begin
            frameCnt = 0;
            errCnt   = 0;
        end else begin
            frameCnt = (frameCnt + 1) % 256;
            if (expErr && errCnt < 255) errCnt++;
        end

        if (checkTiming) checkOutput("startToValid", cycles, FRAME_LEN + 2);
        checkOutput("outValid", {31'd0, bus.out_valid}, 1);
        checkOutput("outParity", {31'd0, bus.out_parity}, {31'd0, expPar});
        checkOutput("outErr", {31'd0, bus.out_err}, {31'd0, expErr});
        checkOutput("frameCnt", {24'd0, frame_cnt}, frameCnt);
        checkOutput("errCnt", {24'd0, err_cnt}, errCnt);
        repeat (outWait) begin
            bus.out_ready = 1'b0;
            @(negedge clk);
            checkOutput("heldValid", {31'd0, bus.out_valid}, 1);
            checkOutput("heldParity", {31'd0, bus.out_parity}, {31'd0, expPar});
            checkOutput("heldErr", {31'd0, bus.out_err}, {31'd0, expErr});
        end
        bus.out_ready = 1'b1;
        start = startAtDone;
        @(negedge clk);
        bus.out_ready = 1'b0;
        start = 1'b0;
        checkOutput("validDropped", {31'd0, bus.out_valid}, 0);
        checkOutput("idleAfterResult", {31'd0, busy}, 0);
    endtask

    // Start a frame, take nBeats beats, then abort (optionally alongside a par handshake).
    task automatic abortStimulus(input int nBeats, input bit atPar);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < nBeats; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = DATA_W'($urandom);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        if (atPar) begin
            bus.par_valid = 1'b1;
            bus.par_bit   = 1'($urandom);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        bus.par_valid = 1'b0;
        checkOutput("abortIdle", {31'd0, busy}, 0);
        checkOutput("abortNoResult", {31'd0, bus.out_valid}, 0);
        checkOutput("abortFrameCnt", {24'd0, frame_cnt}, frameCnt);
        checkOutput("abortErrCnt", {24'd0, err_cnt}, errCnt);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        clr_cnt = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.par_valid = 1'b0;
        bus.par_bit = 1'b0;
        bus.out_ready = 1'b0;

        $display("[TB] reset with random inputs");
        repeat (4) begin
            @(negedge clk);
            start = 1'($urandom); abort = 1'($urandom); clr_cnt = 1'($urandom);
            bus.in_valid = 1'($urandom); bus.in_data = DATA_W'($urandom);
            bus.par_valid = 1'($urandom); bus.par_bit = 1'($urandom); bus.out_ready = 1'($urandom);
            #1;
            checkOutput("rstOutputs", {22'd0, bus.in_ready, bus.par_ready, bus.out_valid,
                        bus.out_err, bus.out_parity, busy, frame_cnt, err_cnt}, 0);
        end
        start = 1'b0; abort = 1'b0; clr_cnt = 1'b0;
        bus.in_valid = 1'b0; bus.par_valid = 1'b0; bus.out_ready = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        checkOutput("postRstInReady", {31'd0, bus.in_ready}, 0);
        checkOutput("postRstBusy", {31'd0, busy}, 0);

        $display("[TB] good frame");
        setBeats(16'b0000_0100_0110_0111);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] bad frame");
        setBeats(16'b0000_0100_0110_1111);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] stalled frame, start while leaving RESULT");
        setBeats(16'b0000_0100_0110_0111);
        applyStimulus(1'b1, 3, 5, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("[TB] start and abort together in IDLE");
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        checkOutput("startAbortIdle", {31'd0, busy}, 0);

        $display("[TB] abort mid-frame, then a full frame");
        abortStimulus(2, 1'b0);
        randomBeats();
        applyStimulus(1'b0, 0, 0, 1'($urandom), 1'b0, 1'b0, 1'b1);
        abortStimulus(FRAME_LEN, 1'b1);

        $display("[TB] random frames");
        repeat (8) begin
            randomBeats();
            applyStimulus(1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                          1'($urandom), 1'b0, 1'b0, 1'b0);
        end

        $display("[TB] saturate error counter");
        while (errCnt < 255) begin
            randomBeats();
            applyStimulus(1'b0, 0, 0, ~refParity(), 1'b0, 1'b0, 1'b0);
        end
        repeat (3) begin
            randomBeats();
            applyStimulus(1'b0, 0, 0, ~refParity(), 1'b0, 1'b0, 1'b0);
        end
        checkOutput("errSaturated", {24'd0, err_cnt}, 255);

        $display("[TB] wrap frame counter");
        while (frameCnt != 255) begin
            randomBeats();
            applyStimulus(1'b0, 0, 0, refParity(), 1'b0, 1'b0, 1'b0);
        end
        randomBeats();
        applyStimulus(1'b0, 0, 0, refParity(), 1'b0, 1'b0, 1'b0);
        checkOutput("frameWrapped", {24'd0, frame_cnt}, 0);

        $display("[TB] clear with simultaneous increment");
        randomBeats();
        applyStimulus(1'b0, 0, 0, ~refParity(), 1'b1, 1'b0, 1'b0);
        checkOutput("clrFrameCnt", {24'd0, frame_cnt}, 0);
        checkOutput("clrErrCnt", {24'd0, err_cnt}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
